// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipe_reg
// Description : ID/EX pipeline register of the mips32 core. It sits directly
//               downstream of hazard detection and captures the decoded
//               operands, register specifiers and control word every cycle.
//               When hazard detection requests a load-use stall (pcWrite_i=0)
//               or a branch flush (idExFlush_i=1), a NOP bubble is loaded
//               instead. Two saturating event counters record how many stall
//               and flush bubbles were inserted.
//
// Ports       : clk            rising-edge clock
//               rst_n          asynchronous active-low reset
//               pcWrite_i      0 = load-use stall, insert bubble
//               idExFlush_i    1 = branch flush, insert bubble (wins over stall)
//               clrCounters_i  synchronous clear of both event counters
//               idValid_i      ID stage holds a real instruction
//               pcPlus4Id_i    PC+4 of the ID instruction            [DW]
//               rd1Id_i        register-file read data port 1        [DW]
//               rd2Id_i        register-file read data port 2        [DW]
//               immId_i        sign-extended immediate               [DW]
//               rsId_i/rtId_i/rdId_i  register specifiers            [5]
//               ctrlId_i       {regWrite,memToReg,memRead,memWrite,
//                               branch,aluSrc,regDst,jump,aluOp[3:0]} [12]
//               validEx_o      EX stage holds a real instruction
//               pcPlus4Ex_o/rd1Ex_o/rd2Ex_o/immEx_o  registered data [DW]
//               rsEx_o/rtEx_o/rdEx_o  registered specifiers          [5]
//               ctrlEx_o       registered control word               [12]
//               memReadEx_o    ctrlEx_o memRead bit, to hazard detection
//               stallCount_o   stall bubbles inserted (saturating)   [CW]
//               flushCount_o   flush bubbles inserted (saturating)   [CW]
//
// Revision    : 1.0  initial release
// ============================================================================
module id_ex_pipe_reg #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pcWrite_i,
    input  logic          idExFlush_i,
    input  logic          clrCounters_i,
    input  logic          idValid_i,
    input  logic [DW-1:0] pcPlus4Id_i,
    input  logic [DW-1:0] rd1Id_i,
    input  logic [DW-1:0] rd2Id_i,
    input  logic [DW-1:0] immId_i,
    input  logic [4:0]    rsId_i,
    input  logic [4:0]    rtId_i,
    input  logic [4:0]    rdId_i,
    input  logic [11:0]   ctrlId_i,
    output logic          validEx_o,
    output logic [DW-1:0] pcPlus4Ex_o,
    output logic [DW-1:0] rd1Ex_o,
    output logic [DW-1:0] rd2Ex_o,
    output logic [DW-1:0] immEx_o,
    output logic [4:0]    rsEx_o,
    output logic [4:0]    rtEx_o,
    output logic [4:0]    rdEx_o,
    output logic [11:0]   ctrlEx_o,
    output logic          memReadEx_o,
    output logic [CW-1:0] stallCount_o,
    output logic [CW-1:0] flushCount_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int            c_CTRL_W       = 12;
    localparam int            c_CTRL_MEMREAD = 9;
    localparam logic [CW-1:0] c_CNT_MAX      = '1;

    // ------------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------------
    logic                validEx_q,   validEx_d;
    logic [DW-1:0]       pcPlus4Ex_q, pcPlus4Ex_d;
    logic [DW-1:0]       rd1Ex_q,     rd1Ex_d;
    logic [DW-1:0]       rd2Ex_q,     rd2Ex_d;
    logic [DW-1:0]       immEx_q,     immEx_d;
    logic [4:0]          rsEx_q,      rsEx_d;
    logic [4:0]          rtEx_q,      rtEx_d;
    logic [4:0]          rdEx_q,      rdEx_d;
    logic [c_CTRL_W-1:0] ctrlEx_q,    ctrlEx_d;
    logic [CW-1:0]       stallCnt_q,  stallCnt_d;
    logic [CW-1:0]       flushCnt_q,  flushCnt_d;

    // ------------------------------------------------------------------------
    // Hazard decode
    // A flush already turns the slot into a bubble, so a simultaneous stall
    // request is not counted as a separate stall event.
    // ------------------------------------------------------------------------
    logic w_flush_evt;
    logic w_stall_evt;
    logic w_bubble;

    assign w_flush_evt = idExFlush_i;
    assign w_stall_evt = ~idExFlush_i & ~pcWrite_i;
    assign w_bubble    = w_flush_evt | w_stall_evt;

    // ------------------------------------------------------------------------
    // Next-state: pipeline fields
    // The register is never held: a stall freezes PC and IF/ID upstream, and
    // this stage must drain the load into EX while feeding a bubble behind
    // it. The bubble clears the whole control word, so memRead drops and the
    // load-use stall ends after exactly one cycle. Data fields are zeroed too
    // so a bubble is a clean, deterministic NOP.
    // ------------------------------------------------------------------------
    always_comb begin
        validEx_d   = 1'b0;
        pcPlus4Ex_d = '0;
        rd1Ex_d     = '0;
        rd2Ex_d     = '0;
        immEx_d     = '0;
        rsEx_d      = '0;
        rtEx_d      = '0;
        rdEx_d      = '0;
        ctrlEx_d    = '0;
        if (!w_bubble) begin
            // An invalid ID slot still passes its control word unmodified;
            // EX qualifies every side effect with validEx.
            validEx_d   = idValid_i;
            pcPlus4Ex_d = pcPlus4Id_i;
            rd1Ex_d     = rd1Id_i;
            rd2Ex_d     = rd2Id_i;
            immEx_d     = immId_i;
            rsEx_d      = rsId_i;
            rtEx_d      = rtId_i;
            rdEx_d      = rdId_i;
            ctrlEx_d    = ctrlId_i;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state: event counters
    // Saturating at all-ones; a clear request overrides any increment.
    // ------------------------------------------------------------------------
    always_comb begin
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        if (clrCounters_i) begin
            stallCnt_d = '0;
            flushCnt_d = '0;
        end else begin
            if (w_stall_evt && (stallCnt_q != c_CNT_MAX)) begin
                stallCnt_d = stallCnt_q + 1'b1;
            end
            if (w_flush_evt && (flushCnt_q != c_CNT_MAX)) begin
                flushCnt_d = flushCnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // Asynchronous reset discards whatever is in flight, including a bubble.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validEx_q   <= 1'b0;
            pcPlus4Ex_q <= '0;
            rd1Ex_q     <= '0;
            rd2Ex_q     <= '0;
            immEx_q     <= '0;
            rsEx_q      <= '0;
            rtEx_q      <= '0;
            rdEx_q      <= '0;
            ctrlEx_q    <= '0;
            stallCnt_q  <= '0;
            flushCnt_q  <= '0;
        end else begin
            validEx_q   <= validEx_d;
            pcPlus4Ex_q <= pcPlus4Ex_d;
            rd1Ex_q     <= rd1Ex_d;
            rd2Ex_q     <= rd2Ex_d;
            immEx_q     <= immEx_d;
            rsEx_q      <= rsEx_d;
            rtEx_q      <= rtEx_d;
            rdEx_q      <= rdEx_d;
            ctrlEx_q    <= ctrlEx_d;
            stallCnt_q  <= stallCnt_d;
            flushCnt_q  <= flushCnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: driven straight from flops, no input-to-output path.
    // ------------------------------------------------------------------------
    assign validEx_o    = validEx_q;
    assign pcPlus4Ex_o  = pcPlus4Ex_q;
    assign rd1Ex_o      = rd1Ex_q;
    assign rd2Ex_o      = rd2Ex_q;
    assign immEx_o      = immEx_q;
    assign rsEx_o       = rsEx_q;
    assign rtEx_o       = rtEx_q;
    assign rdEx_o       = rdEx_q;
    assign ctrlEx_o     = ctrlEx_q;
    assign memReadEx_o  = ctrlEx_q[c_CTRL_MEMREAD];
    assign stallCount_o = stallCnt_q;
    assign flushCount_o = flushCnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_pipe_reg
// Description : Directed self-checking bench for id_ex_pipe_reg. The DUT is
//               built with a 4-bit counter width so saturation is reachable.
// Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_pipe_reg;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int PW = 1 + 4*DW + 15 + 12 + 1;

    logic          clk;
    logic          rst_n;
    logic          pcWrite_i;
    logic          idExFlush_i;
    logic          clrCounters_i;
    logic          idValid_i;
    logic [DW-1:0] pcPlus4Id_i;
    logic [DW-1:0] rd1Id_i;
    logic [DW-1:0] rd2Id_i;
    logic [DW-1:0] immId_i;
    logic [4:0]    rsId_i;
    logic [4:0]    rtId_i;
    logic [4:0]    rdId_i;
    logic [11:0]   ctrlId_i;
    logic          validEx_o;
    logic [DW-1:0] pcPlus4Ex_o;
    logic [DW-1:0] rd1Ex_o;
    logic [DW-1:0] rd2Ex_o;
    logic [DW-1:0] immEx_o;
    logic [4:0]    rsEx_o;
    logic [4:0]    rtEx_o;
    logic [4:0]    rdEx_o;
    logic [11:0]   ctrlEx_o;
    logic          memReadEx_o;
    logic [CW-1:0] stallCount_o;
    logic [CW-1:0] flushCount_o;

    logic [PW-1:0] obs_pipe;
    int            n_checks;
    int            n_fail;
    int            exp_stall;
    int            exp_flush;

    assign obs_pipe = {validEx_o, pcPlus4Ex_o, rd1Ex_o, rd2Ex_o, immEx_o,
                       rsEx_o, rtEx_o, rdEx_o, ctrlEx_o, memReadEx_o};

    id_ex_pipe_reg #(.DW(DW), .CW(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pcWrite_i     (pcWrite_i),
        .idExFlush_i   (idExFlush_i),
        .clrCounters_i (clrCounters_i),
        .idValid_i     (idValid_i),
        .pcPlus4Id_i   (pcPlus4Id_i),
        .rd1Id_i       (rd1Id_i),
        .rd2Id_i       (rd2Id_i),
        .immId_i       (immId_i),
        .rsId_i        (rsId_i),
        .rtId_i        (rtId_i),
        .rdId_i        (rdId_i),
        .ctrlId_i      (ctrlId_i),
        .validEx_o     (validEx_o),
        .pcPlus4Ex_o   (pcPlus4Ex_o),
        .rd1Ex_o       (rd1Ex_o),
        .rd2Ex_o       (rd2Ex_o),
        .immEx_o       (immEx_o),
        .rsEx_o        (rsEx_o),
        .rtEx_o        (rtEx_o),
        .rdEx_o        (rdEx_o),
        .ctrlEx_o      (ctrlEx_o),
        .memReadEx_o   (memReadEx_o),
        .stallCount_o  (stallCount_o),
        .flushCount_o  (flushCount_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run is a few hundred cycles; anything longer is a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Input driver (stimulus only, no checking).
    task automatic drive(input logic pcw, input logic fl, input logic clr,
                         input logic v, input logic [DW-1:0] pc,
                         input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                         input logic [DW-1:0] imm, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic [11:0] ctrl);
        pcWrite_i     = pcw;
        idExFlush_i   = fl;
        clrCounters_i = clr;
        idValid_i     = v;
        pcPlus4Id_i   = pc;
        rd1Id_i       = r1;
        rd2Id_i       = r2;
        immId_i       = imm;
        rsId_i        = rs;
        rtId_i        = rt;
        rdId_i        = rd;
        ctrlId_i      = ctrl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        logic [PW-1:0] exp_p;
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hAAAA_0004, 32'h5555_5555,
              32'h0F0F_0F0F, 32'hFFFF_8000, 5'd1, 5'd2, 5'd3, 12'hFFF);
        #1;
        n_checks++;
        if ((obs_pipe !== '0) || (stallCount_o !== '0) || (flushCount_o !== '0)) begin
            n_fail++;
            $display("FAIL reset_initial: pipe=%h stall=%0d flush=%0d, required all zero",
                     obs_pipe, stallCount_o, flushCount_o);
        end
        tick(); tick();
        n_checks++;
        if (obs_pipe !== '0) begin
            n_fail++;
            $display("FAIL reset_held_over_edges: pipe=%h, required zero", obs_pipe);
        end
        // Release between edges: nothing may be captured until the next edge.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (obs_pipe !== '0) begin
            n_fail++;
            $display("FAIL reset_release_no_edge: pipe=%h, required zero", obs_pipe);
        end
        tick();
        exp_p = {1'b1, 32'hAAAA_0004, 32'h5555_5555, 32'h0F0F_0F0F, 32'hFFFF_8000,
                 5'd1, 5'd2, 5'd3, 12'hFFF, 1'b1};
        n_checks++;
        if (obs_pipe !== exp_p) begin
            n_fail++;
            $display("FAIL reset_first_capture: pipe=%h, required %h", obs_pipe, exp_p);
        end
        // Put a flush bubble in flight, then assert reset mid-cycle.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h1, 32'h2, 32'h3, 32'h4,
              5'd5, 5'd6, 5'd7, 12'h3FF);
        tick();
        n_checks++;
        if (flushCount_o !== 4'd1) begin
            n_fail++;
            $display("FAIL reset_pre_flush_count: flushCount=%0d, required 1", flushCount_o);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D,
              32'h1357_9BDF, 32'h2468_ACE0, 5'd31, 5'd30, 5'd29, 12'hABC);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ((obs_pipe !== '0) || (stallCount_o !== '0) || (flushCount_o !== '0)) begin
            n_fail++;
            $display("FAIL reset_async_midcycle: pipe=%h stall=%0d flush=%0d, required all zero",
                     obs_pipe, stallCount_o, flushCount_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_normal_flow();
        logic [PW-1:0] exp_p;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0004, 32'h0000_1234,
              32'h0000_BEEF, 32'hFFFF_FFF0, 5'd3, 5'd7, 5'd9, 12'h204);
        tick();
        exp_p = {1'b1, 32'h0040_0004, 32'h0000_1234, 32'h0000_BEEF, 32'hFFFF_FFF0,
                 5'd3, 5'd7, 5'd9, 12'h204, 1'b1};
        n_checks++;
        if (obs_pipe !== exp_p) begin
            n_fail++;
            $display("FAIL normal_capture: pipe=%h, required %h", obs_pipe, exp_p);
        end
        // Invalid ID slot: fields still captured, control passed unmodified.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0008, 32'h0000_00AA,
              32'h0000_00BB, 32'h0000_0010, 5'd4, 5'd5, 5'd6, 12'hABC);
        tick();
        exp_p = {1'b0, 32'h0040_0008, 32'h0000_00AA, 32'h0000_00BB, 32'h0000_0010,
                 5'd4, 5'd5, 5'd6, 12'hABC, 1'b1};
        n_checks++;
        if (obs_pipe !== exp_p) begin
            n_fail++;
            $display("FAIL invalid_passthrough: pipe=%h, required %h", obs_pipe, exp_p);
        end
        n_checks++;
        if ((stallCount_o !== 4'(exp_stall)) || (flushCount_o !== 4'(exp_flush))) begin
            n_fail++;
            $display("FAIL normal_counters: stall=%0d flush=%0d, required %0d %0d",
                     stallCount_o, flushCount_o, exp_stall, exp_flush);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_load_use();
        // Load (memRead set) enters EX.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0010, 32'h0000_1000,
              32'h0, 32'h0000_0004, 5'd8, 5'd10, 5'd0, 12'hE40);
        tick();
        n_checks++;
        if ((memReadEx_o !== 1'b1) || (rtEx_o !== 5'd10)) begin
            n_fail++;
            $display("FAIL loaduse_load_in_ex: memReadEx=%b rtEx=%0d, required 1 10",
                     memReadEx_o, rtEx_o);
        end
        // Dependent instruction stalls for one cycle.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0014, 32'h0000_0777,
              32'h0000_0888, 32'h0, 5'd10, 5'd11, 5'd12, 12'h822);
        tick();
        exp_stall++;
        n_checks++;
        if ((obs_pipe !== '0) || (memReadEx_o !== 1'b0)) begin
            n_fail++;
            $display("FAIL loaduse_bubble: pipe=%h memReadEx=%b, required zero", obs_pipe, memReadEx_o);
        end
        n_checks++;
        if ((stallCount_o !== 4'(exp_stall)) || (flushCount_o !== 4'(exp_flush))) begin
            n_fail++;
            $display("FAIL loaduse_counters: stall=%0d flush=%0d, required %0d %0d",
                     stallCount_o, flushCount_o, exp_stall, exp_flush);
        end
        // Stall released: same instruction now captured.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0014, 32'h0000_0777,
              32'h0000_0888, 32'h0, 5'd10, 5'd11, 5'd12, 12'h822);
        tick();
        n_checks++;
        if ((validEx_o !== 1'b1) || (ctrlEx_o !== 12'h822) || (rd2Ex_o !== 32'h0000_0888)
            || (stallCount_o !== 4'(exp_stall))) begin
            n_fail++;
            $display("FAIL loaduse_resume: valid=%b ctrl=%h rd2=%h stall=%0d, required 1 822 00000888 %0d",
                     validEx_o, ctrlEx_o, rd2Ex_o, stallCount_o, exp_stall);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_flush_stall();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0040_0020, 32'h1111_1111,
              32'h2222_2222, 32'h3333_3333, 5'd1, 5'd2, 5'd3, 12'hFFF);
        tick();
        exp_flush++;
        n_checks++;
        if (obs_pipe !== '0) begin
            n_fail++;
            $display("FAIL flushstall_bubble: pipe=%h, required zero", obs_pipe);
        end
        n_checks++;
        if ((stallCount_o !== 4'(exp_stall)) || (flushCount_o !== 4'(exp_flush))) begin
            n_fail++;
            $display("FAIL flushstall_counters: stall=%0d flush=%0d, required %0d %0d",
                     stallCount_o, flushCount_o, exp_stall, exp_flush);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [PW-1:0] exp_p;
        // Clear counters during a normal capture.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0,
              5'd0, 5'd0, 5'd0, 12'h000);
        tick();
        exp_stall = 0;
        exp_flush = 0;
        n_checks++;
        if ((stallCount_o !== 4'd0) || (flushCount_o !== 4'd0)) begin
            n_fail++;
            $display("FAIL b2b_clear: stall=%0d flush=%0d, required 0 0", stallCount_o, flushCount_o);
        end
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0100 + 32'(4*i), 32'(i),
                  32'(i+100), 32'(i+200), 5'(i), 5'(i+1), 5'(i+2), 12'hC00 + 12'(i));
            tick();
            exp_flush++;
            n_checks++;
            if ((obs_pipe !== '0) || (flushCount_o !== 4'(exp_flush))) begin
                n_fail++;
                $display("FAIL b2b_flush_%0d: pipe=%h flush=%0d, required zero %0d",
                         i, obs_pipe, flushCount_o, exp_flush);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0110, 32'h0000_0044,
              32'h0000_0055, 32'h0000_0066, 5'd20, 5'd21, 5'd22, 12'h8A1);
        tick();
        exp_p = {1'b1, 32'h0040_0110, 32'h0000_0044, 32'h0000_0055, 32'h0000_0066,
                 5'd20, 5'd21, 5'd22, 12'h8A1, 1'b0};
        n_checks++;
        if ((obs_pipe !== exp_p) || (flushCount_o !== 4'd3) || (stallCount_o !== 4'd0)) begin
            n_fail++;
            $display("FAIL b2b_fourth: pipe=%h flush=%0d stall=%0d, required %h 3 0",
                     obs_pipe, flushCount_o, stallCount_o, exp_p);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_saturation();
        int sat_errs;
        sat_errs = 0;
        // Counter starts at 3 from the previous scenario.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 32'(i), 32'(i), 32'(i), 32'(i),
                  5'd1, 5'd1, 5'd1, 12'h111);
            tick();
            if (exp_flush < 15) exp_flush++;
            n_checks++;
            if (flushCount_o !== 4'(exp_flush)) begin
                n_fail++;
                sat_errs++;
                if (sat_errs <= 4)
                    $display("FAIL sat_flush_step_%0d: flushCount=%0d, required %0d",
                             i, flushCount_o, exp_flush);
            end
        end
        n_checks++;
        if (flushCount_o !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_flush_final: flushCount=%0d, required 15", flushCount_o);
        end
        // Stall counter saturates too.
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0,
                  5'd0, 5'd0, 5'd0, 12'h200);
            tick();
        end
        n_checks++;
        if ((stallCount_o !== 4'd15) || (flushCount_o !== 4'd15)) begin
            n_fail++;
            $display("FAIL sat_stall_final: stall=%0d flush=%0d, required 15 15",
                     stallCount_o, flushCount_o);
        end
        // Clear wins over a simultaneous flush.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0,
              5'd0, 5'd0, 5'd0, 12'h000);
        tick();
        n_checks++;
        if ((flushCount_o !== 4'd0) || (stallCount_o !== 4'd0)) begin
            n_fail++;
            $display("FAIL sat_clear_with_flush: flush=%0d stall=%0d, required 0 0",
                     flushCount_o, stallCount_o);
        end
        // Counting resumes from zero after the clear.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0,
              5'd0, 5'd0, 5'd0, 12'h000);
        tick();
        n_checks++;
        if ((stallCount_o !== 4'd1) || (flushCount_o !== 4'd0)) begin
            n_fail++;
            $display("FAIL sat_resume: stall=%0d flush=%0d, required 1 0",
                     stallCount_o, flushCount_o);
        end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_stall = 0;
        exp_flush = 0;
        test_reset();
        test_normal_flow();
        test_load_use();
        test_flush_stall();
        test_back_to_back();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
